// File: rtl/booth_seq_mul.sv
// booth_seq_mul: multi-cycle radix-2 Booth multiplier, one add/sub-and-shift per clock.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled when ready (IDLE or DONE)
//   a, b   WIDTH-bit operands (two's complement unless tc=0), sampled with start
//   tc     (UNSIGNED_EN only) 1 = signed operands, 0 = unsigned operands
//   c      2*WIDTH-bit product, updated only on the done edge
//   busy   high while stepping (RUN)
//   done   one-cycle pulse when c has just been updated
//
// Build option: define UNSIGNED_EN to add the tc port and unsigned mode.
// Unsigned mode takes WIDTH+1 steps. Signed mode always takes WIDTH steps.
module booth_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef UNSIGNED_EN
    input  logic                 tc,
`endif
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy,
    output logic                 done
);

`ifdef UNSIGNED_EN
    // Operands are extended by one bit so unsigned values fit as positive
    // two's-complement numbers.
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [EW:0]         m_q, m_d;        // sign-extended multiplicand
    logic [EW:0]         acc_q, acc_d;    // accumulator, one guard bit above EW
    logic [EW-1:0]       q_q, q_d;        // multiplier / low product bits
    logic                q1_q, q1_d;      // Booth look-behind bit
    logic [CW-1:0]       cnt_q, cnt_d;    // remaining steps
    logic [2*WIDTH-1:0]  c_q, c_d;
`ifdef UNSIGNED_EN
    logic                sgn_q, sgn_d;
`endif

    // Values loaded when a request is accepted.
    logic [EW:0]         m_ld;
    logic [EW-1:0]       q_ld;
    logic [CW-1:0]       cnt_ld;

    always_comb begin
`ifdef UNSIGNED_EN
        if (tc) begin
            m_ld   = {{2{a[WIDTH-1]}}, a};
            q_ld   = {b[WIDTH-1], b};
            cnt_ld = CW'(WIDTH);
        end else begin
            m_ld   = {2'b00, a};
            q_ld   = {1'b0, b};
            cnt_ld = CW'(WIDTH + 1);
        end
`else
        m_ld   = {a[WIDTH-1], a};
        q_ld   = b;
        cnt_ld = CW'(WIDTH);
`endif
    end

    // One Booth step on the current registers.
    logic [EW:0]         sum;
    logic [EW:0]         acc_sh;
    logic [EW-1:0]       q_sh;
    logic [2*WIDTH-1:0]  res;

    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        acc_sh = {sum[EW], sum[EW:1]};
        q_sh   = {sum[0], q_q[EW-1:1]};
`ifdef UNSIGNED_EN
        // Signed mode stops one step early, so the product sits one bit
        // higher in {acc,q}; the unused extension bit is left in q[0].
        if (sgn_q) res = {acc_sh[WIDTH-1:0], q_sh[WIDTH:1]};
        else       res = {acc_sh[WIDTH-2:0], q_sh};
`else
        res = {acc_sh[WIDTH-1:0], q_sh};
`endif
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
`ifdef UNSIGNED_EN
        sgn_d   = sgn_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = m_ld;
                    acc_d   = '0;
                    q_d     = q_ld;
                    q1_d    = 1'b0;
                    cnt_d   = cnt_ld;
`ifdef UNSIGNED_EN
                    sgn_d   = tc;
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                q1_d  = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    c_d     = res;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            c_q     <= '0;
`ifdef UNSIGNED_EN
            sgn_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
`ifdef UNSIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign c    = c_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
